alu_share_arbiter: RTL and testbench

Shares one 4-bit ALU (ADD, SUB, AND, SHL) between NUM_REQ requesters on the seven-segment lab board.
- Round-robin arbitration over per-requester valid/ready request channels.
- Operands are latched and the ALU result is registered.
- Each result is returned on a single response channel tagged with the requester ID.
- Sits between switch/debounce front-ends or test masters and the display datapath.

---
 rtl/alu_share_pkg.sv | 21 ++
 rtl/alu_share_arbiter_if.sv | 34 +++
 rtl/alu_share_arbiter_alu4_core.sv | 31 +++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// alu_share_pkg
// Shared types for the ALU-sharing arbiter: the ALU opcode encoding seen on
// the request channels and the arbiter FSM state encoding.
package alu_share_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_SUB = 2'b10,
    ALU_SHL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the per-requester request channels, the single tagged response
// channel and the status outputs of the ALU-sharing arbiter.
//   master : requester/consumer side (drives requests and resp_ready)
//   slave  : arbiter side (drives req_ready, response and status)
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0] req_op;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [3:0]           resp_data;
  logic                 resp_carry;
  logic                 busy;
  logic [CNT_W-1:0]     op_count;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_carry, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_carry, busy, op_count
  );
endinterface

// File: rtl/alu_share_arbiter_alu4_core.sv
// alu4_core
// Combinational 4-bit ALU shared by all requesters.
//   a, b  : 4-bit operands
//   op    : ADD / AND / SUB / SHL
//   data  : 4-bit result
//   carry : ADD carry-out, SUB no-borrow (a >= b), 0 for AND/SHL
module alu4_core
  import alu_share_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  alu_op_e    op,
  output logic [3:0] data,
  output logic       carry
);

  always_comb begin
    data  = 4'd0;
    carry = 1'b0;
    case (op)
      ALU_ADD: {carry, data} = {1'b0, a} + {1'b0, b};
      // Two's-complement subtract; the carry out of a + ~b + 1 is the no-borrow flag.
      ALU_SUB: {carry, data} = {1'b0, a} + {1'b0, ~b} + 5'd1;
      ALU_AND: data = a & b;
      // Shift amounts of 4 or more flush every bit out.
      ALU_SHL: data = (b[3:2] != 2'b00) ? 4'd0 : (a << b[1:0]);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin shares one 4-bit ALU among NUM_REQ requesters. A winner's
// operands are latched on acceptance, the ALU result is registered one cycle
// later and held on the tagged response channel until the consumer takes it.
//   clk   : system clock
//   reset : asynchronous active-high reset (drops any in-flight operation)
//   bus   : request channels, response channel, busy and op_count (slave side)
//
//   state | meaning
//   IDLE  | waiting for any req_valid; accepts the round-robin winner
//   EXEC  | latched operands are at the ALU; result registered on exit
//   RESP  | resp_valid high, result held until resp_ready
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  // Search starts just above the last served requester and wraps; scanning
  // offsets from high to low lets the nearest valid requester win.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  grant;
  logic             accept;
  logic [NUM_REQ-1:0] ready;

  logic [3:0]       a_q, b_q;
  alu_op_e          op_q;
  logic [ID_W-1:0]  g_q;

  logic [3:0]       alu_data;
  logic             alu_carry;
  logic [3:0]       resp_data_q;
  logic             resp_carry_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [CNT_W-1:0] op_count_q;
  logic             handshake;

  assign grant     = rr_pick(bus.req_valid, last_grant_q);
  assign accept    = (state_q == IDLE) && (|bus.req_valid);
  assign handshake = (state_q == RESP) && bus.resp_ready;

  always_comb begin
    state_d = state_q;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ready[grant] = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_ID;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      op_q         <= ALU_ADD;
      g_q          <= '0;
      resp_data_q  <= 4'd0;
      resp_carry_q <= 1'b0;
      resp_id_q    <= '0;
      op_count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= bus.req_a[int'(grant)*4 +: 4];
        b_q  <= bus.req_b[int'(grant)*4 +: 4];
        op_q <= alu_op_e'(bus.req_op[int'(grant)*2 +: 2]);
        g_q  <= grant;
      end
      if (state_q == EXEC) begin
        resp_data_q  <= alu_data;
        resp_carry_q <= alu_carry;
        resp_id_q    <= g_q;
      end
      if (handshake) begin
        last_grant_q <= g_q;
        op_count_q   <= op_count_q + 1'b1;
      end
    end
  end

  alu4_core u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .data  (alu_data),
    .carry (alu_carry)
  );

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Transaction-level model of the arbiter (outstanding op, round-robin pointer,
// arithmetic ALU) checked against the DUT every cycle, plus literal checks on
// directed scenarios.
module tb_alu_share_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(N), .CNT_W(8)) bus();

  alu_share_arbiter #(.NUM_REQ(N), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  int m_busy, m_age, m_last, m_id, m_data, m_carry, m_count;
  int grant_log[$];
  int rid_log[$], rdata_log[$], rcarry_log[$];
  int hs_count = 0;

  function automatic int model_pick(input int valid, input int last);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (last + off) % N;
      if (((valid >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic model_alu(input int a, input int b, input int op,
                           output int d, output int c);
    int s;
    d = 0; c = 0;
    case (op)
      0: begin s = a + b; d = s % 16; c = s / 16; end
      1: begin d = a & b; c = 0; end
      2: begin d = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
      default: begin d = (b >= 4) ? 0 : ((a << b) % 16); c = 0; end
    endcase
  endtask

  int v, g, exp_ready, ma, mb, mop;

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 0; m_age = 0; m_last = N - 1; m_count = 0;
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_op_count", bus.op_count, 0);
      check("rst_resp_data", bus.resp_data, 0);
      check("rst_resp_carry", bus.resp_carry, 0);
      check("rst_resp_id", bus.resp_id, 0);
    end else begin
      v = int'(bus.req_valid);
      g = (m_busy == 0) ? model_pick(v, m_last) : -1;
      exp_ready = (g >= 0) ? (1 << g) : 0;
      check("req_ready", bus.req_ready, exp_ready);
      check("busy", bus.busy, m_busy);
      check("resp_valid", bus.resp_valid, (m_busy != 0 && m_age >= 1) ? 1 : 0);
      check("op_count", bus.op_count, m_count);
      if (m_busy != 0 && m_age >= 1) begin
        check("resp_id", bus.resp_id, m_id);
        check("resp_data", bus.resp_data, m_data);
        check("resp_carry", bus.resp_carry, m_carry);
      end
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) grant_log.push_back(i);
      if (bus.resp_valid && bus.resp_ready) begin
        rid_log.push_back(int'(bus.resp_id));
        rdata_log.push_back(int'(bus.resp_data));
        rcarry_log.push_back(int'(bus.resp_carry));
        hs_count++;
      end
      // advance model to the next cycle
      if (g >= 0) begin
        ma  = int'(bus.req_a[g*4 +: 4]);
        mb  = int'(bus.req_b[g*4 +: 4]);
        mop = int'(bus.req_op[g*2 +: 2]);
        model_alu(ma, mb, mop, m_data, m_carry);
        m_id = g; m_busy = 1; m_age = 0;
      end else if (m_busy != 0 && m_age == 0) begin
        m_age = 1;
      end else if (m_busy != 0 && bus.resp_ready) begin
        m_busy = 0; m_last = m_id; m_count = (m_count + 1) % 256;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input int a, input int b, input int op, input bit vld);
    bus.req_a[i*4 +: 4]  = 4'(a);
    bus.req_b[i*4 +: 4]  = 4'(b);
    bus.req_op[i*2 +: 2] = 2'(op);
    bus.req_valid[i]     = vld;
  endtask

  // Returns at posedge+1 of the cycle following the grant (EXEC cycle).
  task automatic wait_grant(input int i);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.req_ready[i]) break;
      n++;
    end
    if (n >= 20) check("grant_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) break;
      n++;
    end
    if (n >= 20) check("resp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Valid is dropped and operands scrambled right after acceptance; neither
  // may disturb the operation in flight.
  task automatic run_op(input int i, input int a, input int b, input int op);
    drive(i, a, b, op, 1'b1);
    wait_grant(i);
    drive(i, 15, 15, 3, 1'b0);
    wait_resp();
  endtask

  task automatic check_last(input string name, input int id, input int d, input int c);
    check({name, "_id"}, rid_log[$], id);
    check({name, "_data"}, rdata_log[$], d);
    check({name, "_carry"}, rcarry_log[$], c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  int base, hs0, d0, id0;
  int exp_order[5];
  int exp_rr_data[5];

  initial begin
    exp_order   = '{0, 1, 2, 3, 0};
    exp_rr_data = '{2, 2, 14, 8, 2};
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus.resp_ready = 1'b1;   // ready before any response: must be harmless

    // 1: ADD 9+8
    run_op(0, 9, 8, 0);
    check_last("t1", 0, 1, 1);
    check("t1_op_count", bus.op_count, 1);

    // 2: SUB both directions from requester 2
    run_op(2, 3, 5, 2);
    check_last("t2a", 2, 14, 0);
    run_op(2, 5, 3, 2);
    check_last("t2b", 2, 2, 1);

    // 4: single requester (3) served repeatedly; also leaves pointer at 3
    run_op(3, 3, 2, 3);
    check_last("t4_shl2", 3, 12, 0);
    run_op(3, 3, 5, 3);
    check_last("t4_shl5", 3, 0, 0);
    run_op(3, 12, 10, 1);
    check_last("t4_and", 3, 8, 0);
    run_op(3, 15, 1, 0);
    check_last("t4_add_wrap", 3, 0, 1);

    // 3: all requesters valid -> strict rotation
    base = grant_log.size();
    drive(0, 1, 1, 0, 1'b1);
    drive(1, 6, 3, 1, 1'b1);
    drive(2, 7, 9, 2, 1'b1);
    drive(3, 1, 3, 3, 1'b1);
    for (int k = 0; k < 5; k++) wait_resp();
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_grant%0d", k), grant_log[base + k], exp_order[k]);
      check($sformatf("t3_data%0d", k), rdata_log[rdata_log.size() - 5 + k], exp_rr_data[k]);
    end

    // 5: back-pressure holds the response stable
    bus.resp_ready = 1'b0;
    drive(1, 10, 7, 0, 1'b1);
    drive(0, 4, 4, 2, 1'b1);
    wait_grant(1);
    begin
      int n;
      n = 0;
      while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
      if (n >= 10) check("t5_valid_timeout", 0, 1);
    end
    d0 = int'(bus.resp_data); id0 = int'(bus.resp_id);
    check("t5_data", d0, 1);
    check("t5_id", id0, 1);
    repeat (5) begin
      @(negedge clk);
      check("t5_hold_valid", bus.resp_valid, 1);
      check("t5_hold_data", bus.resp_data, d0);
      check("t5_hold_id", bus.resp_id, id0);
      check("t5_hold_ready", bus.req_ready, 0);
      check("t5_hold_busy", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    wait_resp();
    bus.req_valid = '0;

    // 6: reset during EXEC drops the operation
    drive(0, 5, 5, 0, 1'b1);
    wait_grant(0);
    reset = 1'b1;
    bus.req_valid = '0;
    #1;
    check("t6_valid", bus.resp_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_count", bus.op_count, 0);
    check("t6_ready", bus.req_ready, 0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    hs0 = hs_count;
    drive(0, 2, 3, 0, 1'b1);
    drive(1, 1, 1, 0, 1'b1);
    wait_grant(0);
    bus.req_valid = '0;
    wait_resp();
    check_last("t6_after", 0, 5, 0);
    check("t6_resp_count", hs_count - hs0, 1);
    check("t6_op_count", bus.op_count, 1);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
